// File: rtl/vec_wb_arbiter.sv
// Vector writeback stage: round-robin merge of ALU and load results into an
// in-order FIFO that drains one register-file write per cycle, plus a pending-write scoreboard.
module vec_wb_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [2:0]               alu_addr,
   input  logic [WIDTH-1:0]         alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [2:0]               mem_addr,
   input  logic [WIDTH-1:0]         mem_data,
   input  logic                     alloc_valid,
   input  logic [2:0]               alloc_addr,
   input  logic                     wb_stall,
   output logic [7:0]               pending,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     rf_we,
   output logic [2:0]               rf_wr_addr,
   output logic [WIDTH-1:0]         rf_wr_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_t;

   grant_t           last_grant;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [2:0]       addr_q [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];

   logic             full, conflict, alu_acc, mem_acc, accept, drain;
   logic [2:0]       in_addr;
   logic [WIDTH-1:0] in_data;
   logic [7:0]       pending_n;

   // Readies look only at occupancy before this edge's drain, so a full FIFO
   // never takes a new entry even in the cycle it frees a slot.
   assign full      = (count == FULL_CNT);
   assign conflict  = alu_valid && mem_valid;
   assign alu_ready = !rst && !full && !(conflict && last_grant == GRANT_ALU);
   assign mem_ready = !rst && !full && !(conflict && last_grant == GRANT_MEM);
   assign alu_acc   = alu_valid && alu_ready;
   assign mem_acc   = mem_valid && mem_ready;
   assign accept    = alu_acc || mem_acc;
   assign in_addr   = mem_acc ? mem_addr : alu_addr;
   assign in_data   = mem_acc ? mem_data : alu_data;

   assign rf_we      = !rst && (count != '0) && !wb_stall;
   assign drain      = rf_we;
   assign rf_wr_addr = (count != '0) ? addr_q[rd_ptr] : 3'd0;
   assign rf_wr_data = (count != '0) ? data_q[rd_ptr] : '0;

   // Alloc is applied after the drain clear so a same-address collision ends set.
   always_comb begin
      // NOTE: assign a default before any conditional update; a path that leaves
      // pending_n unassigned would infer a latch.
      pending_n = pending;
      if (drain)
         pending_n[rf_wr_addr] = 1'b0;
      if (alloc_valid)
         pending_n[alloc_addr] = 1'b1;
   end

   // NOTE: FIFO storage is deliberately left out of reset; entries are only ever
   // read while count says they hold valid data, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q[wr_ptr] <= in_addr;
         data_q[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every block sees
      // pre-edge values regardless of evaluation order.
      if (rst) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pending    <= '0;
         last_grant <= GRANT_ALU;
      end else begin
         count   <= count + CW'(accept) - CW'(drain);
         pending <= pending_n;
         if (accept) begin
            wr_ptr     <= wr_ptr + AW'(1);
            last_grant <= mem_acc ? GRANT_MEM : GRANT_ALU;
         end
         if (drain)
            rd_ptr <= rd_ptr + AW'(1);
      end
   end

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Directed self-checking bench for vec_wb_arbiter: arbitration, FIFO ordering,
// full/stall handling, scoreboard collisions and mid-operation reset.
module tb_vec_wb_arbiter;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             alu_valid, alu_ready, mem_valid, mem_ready;
   logic [2:0]       alu_addr, mem_addr, alloc_addr, rf_wr_addr;
   logic [WIDTH-1:0] alu_data, mem_data, rf_wr_data;
   logic             alloc_valid, wb_stall, rf_we;
   logic [7:0]       pending;
   logic [2:0]       count;

   int compared   = 0;
   int mismatched = 0;

   vec_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .wb_stall(wb_stall),
      .pending(pending), .count(count),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
   );

   always #5 clk = ~clk;

   // Protocol rules on the issue stage and producers, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         assert (!(alloc_valid && pending[alloc_addr] && !(rf_we && rf_wr_addr == alloc_addr)))
            else begin mismatched++; $error("FAIL assert_alloc_pending addr=%0d pending=%h", alloc_addr, pending); end
         assert (!(alu_valid && alu_ready && !pending[alu_addr]))
            else begin mismatched++; $error("FAIL assert_alu_nonpending addr=%0d pending=%h", alu_addr, pending); end
         assert (!(mem_valid && mem_ready && !pending[mem_addr]))
            else begin mismatched++; $error("FAIL assert_mem_nonpending addr=%0d pending=%h", mem_addr, pending); end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      mem_valid = 0; mem_addr = 0; mem_data = 0;
      alloc_valid = 0; alloc_addr = 0; wb_stall = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic alloc(input logic [2:0] a);
      alloc_valid = 1; alloc_addr = a;
      tick();
      alloc_valid = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      alu_valid = 1; mem_valid = 1;
      #1;
      compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL reset_count got=%0d exp=0", count); end
      compared++; if (pending !== 8'h00) begin mismatched++; $display("FAIL reset_pending got=%h exp=00", pending); end
      compared++; if ({alu_ready, mem_ready, rf_we} !== 3'b000) begin mismatched++; $display("FAIL reset_ctrl got=%b exp=000", {alu_ready, mem_ready, rf_we}); end
      compared++; if ({rf_wr_addr, rf_wr_data} !== '0) begin mismatched++; $display("FAIL reset_rf got=%0d/%h exp=0/0", rf_wr_addr, rf_wr_data); end
      tick(); tick();
      rst = 0; idle();
      tick();
   endtask

   task automatic test_single();
      alloc(3'd3);
      compared++; if (pending !== 8'h08) begin mismatched++; $display("FAIL single_alloc got=%h exp=08", pending); end
      alu_valid = 1; alu_addr = 3; alu_data = 32'hDEADBEEF;
      #1;
      compared++; if (alu_ready !== 1'b1 || rf_we !== 1'b0) begin mismatched++; $display("FAIL single_ready got=%b%b exp=10", alu_ready, rf_we); end
      tick();
      alu_valid = 0;
      #1;
      compared++; if ({rf_we, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd3, 32'hDEADBEEF}) begin
         mismatched++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/deadbeef", rf_we, rf_wr_addr, rf_wr_data); end
      compared++; if (count !== 3'd1) begin mismatched++; $display("FAIL single_count1 got=%0d exp=1", count); end
      tick();
      compared++; if ({pending, count, rf_we} !== {8'h00, 3'd0, 1'b0}) begin
         mismatched++; $display("FAIL single_done got=%h/%0d/%b exp=00/0/0", pending, count, rf_we); end
   endtask

   task automatic test_conflict();
      do_reset();
      alloc(3'd1);
      alloc(3'd2);
      alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
      mem_valid = 1; mem_addr = 2; mem_data = 32'h22;
      #1;
      compared++; if ({mem_ready, alu_ready} !== 2'b10) begin mismatched++; $display("FAIL conflict_first got=%b exp=10", {mem_ready, alu_ready}); end
      tick();
      mem_valid = 0;
      #1;
      compared++; if (alu_ready !== 1'b1) begin mismatched++; $display("FAIL conflict_alu_next got=%b exp=1", alu_ready); end
      compared++; if ({rf_we, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd2, 32'h22}) begin
         mismatched++; $display("FAIL conflict_wb0 got=%b/%0d/%h exp=1/2/22", rf_we, rf_wr_addr, rf_wr_data); end
      tick();
      alu_valid = 0;
      #1;
      compared++; if ({rf_we, rf_wr_addr, rf_wr_data, count} !== {1'b1, 3'd1, 32'h11, 3'd1}) begin
         mismatched++; $display("FAIL conflict_wb1 got=%b/%0d/%h/%0d exp=1/1/11/1", rf_we, rf_wr_addr, rf_wr_data, count); end
      tick();
      compared++; if ({count, pending} !== {3'd0, 8'h00}) begin mismatched++; $display("FAIL conflict_done got=%0d/%h exp=0/00", count, pending); end
   endtask

   task automatic test_full();
      for (int i = 4; i < 8; i++) alloc(3'(i));
      alloc(3'd0);
      wb_stall = 1;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1; alu_addr = 3'(4 + i); alu_data = 32'hA0 + 32'(i);
         #1;
         compared++; if (alu_ready !== 1'b1) begin mismatched++; $display("FAIL full_fill%0d got=%b exp=1", i, alu_ready); end
         tick();
      end
      alu_addr = 0; alu_data = 32'hB0;
      #1;
      compared++; if ({count, alu_ready, rf_we} !== {3'd4, 1'b0, 1'b0}) begin
         mismatched++; $display("FAIL full_block got=%0d/%b/%b exp=4/0/0", count, alu_ready, rf_we); end
      tick();
      compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL full_hold got=%0d exp=4", count); end
   endtask

   task automatic test_release_at_full();
      logic [2:0]  exp_addr [5];
      logic [31:0] exp_data [5];
      exp_addr = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0};
      wb_stall = 0;
      #1;
      compared++; if (alu_ready !== 1'b0) begin mismatched++; $display("FAIL release_no_pass got=%b exp=0", alu_ready); end
      for (int i = 0; i < 5; i++) begin
         #1;
         compared++; if ({rf_we, rf_wr_addr, rf_wr_data} !== {1'b1, exp_addr[i], exp_data[i]}) begin
            mismatched++; $display("FAIL release_wb%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_wr_addr, rf_wr_data, exp_addr[i], exp_data[i]); end
         tick();
         if (i == 0) begin
            compared++; if ({count, alu_ready} !== {3'd3, 1'b1}) begin
               mismatched++; $display("FAIL release_after_drain got=%0d/%b exp=3/1", count, alu_ready); end
         end
         if (i == 1) begin
            alu_valid = 0;
            compared++; if (count !== 3'd3) begin mismatched++; $display("FAIL release_accept_drain got=%0d exp=3", count); end
         end
      end
      compared++; if ({count, rf_we, pending} !== {3'd0, 1'b0, 8'h00}) begin
         mismatched++; $display("FAIL release_done got=%0d/%b/%h exp=0/0/00", count, rf_we, pending); end
   endtask

   task automatic test_alloc_drain_same();
      alloc(3'd5);
      wb_stall = 1;
      alu_valid = 1; alu_addr = 5; alu_data = 32'h55;
      tick();
      alu_valid = 0; wb_stall = 0;
      alloc_valid = 1; alloc_addr = 5;
      #1;
      compared++; if ({rf_we, rf_wr_addr} !== {1'b1, 3'd5}) begin mismatched++; $display("FAIL same_drain got=%b/%0d exp=1/5", rf_we, rf_wr_addr); end
      tick();
      alloc_valid = 0;
      compared++; if ({pending, count} !== {8'h20, 3'd0}) begin mismatched++; $display("FAIL same_pending got=%h/%0d exp=20/0", pending, count); end
      alu_valid = 1; alu_addr = 5; alu_data = 32'h56;
      tick();
      alu_valid = 0;
      tick();
      compared++; if (pending !== 8'h00) begin mismatched++; $display("FAIL same_clear got=%h exp=00", pending); end
   endtask

   task automatic test_reset_mid();
      for (int i = 1; i < 4; i++) alloc(3'(i));
      wb_stall = 1;
      for (int i = 1; i < 4; i++) begin
         alu_valid = 1; alu_addr = 3'(i); alu_data = 32'hC0 + 32'(i);
         tick();
      end
      alu_valid = 0;
      compared++; if (count !== 3'd3) begin mismatched++; $display("FAIL rstmid_count got=%0d exp=3", count); end
      wb_stall = 0; rst = 1; alu_valid = 1; alu_addr = 1; mem_valid = 1; mem_addr = 2;
      #1;
      compared++; if ({rf_we, alu_ready, mem_ready, pending, count} !== {3'b000, 8'h00, 3'd0}) begin
         mismatched++; $display("FAIL rstmid_now got=%b%b%b/%h/%0d exp=000/00/0", rf_we, alu_ready, mem_ready, pending, count); end
      tick();
      rst = 0; idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         compared++; if ({rf_we, count} !== {1'b0, 3'd0}) begin mismatched++; $display("FAIL rstmid_stale%0d got=%b/%0d exp=0/0", i, rf_we, count); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_conflict();
      test_full();
      test_release_at_full();
      test_alloc_drain_same();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vec_wb_arbiter.md
Name: vec_wb_arbiter

Overview:
- Writeback stage directly upstream of the 8-entry vector register file; owns its write port (we, wr_addr, wr_data).
- Merges results from two producers, the vector ALU and the vector load unit (MEM), through a round-robin arbiter into a small in-order writeback FIFO.
- Drains the FIFO at one register write per cycle.
- Keeps an 8-bit pending-write scoreboard for the issue stage's RAW hazard check.

Parameters:
WIDTH, 32, data width of one register; must equal the register file WIDTH
DEPTH, 4, writeback FIFO entries; power of 2, >= 2
- Register address width is fixed at 3 (8 registers); not a parameter.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
alu_addr  in  3  ALU destination register
alu_data  in  WIDTH  ALU result
mem_valid  in  1  load result valid
mem_ready  out  1  load result accepted this cycle when mem_valid && mem_ready
mem_addr  in  3  load destination register
mem_data  in  WIDTH  load data
alloc_valid  in  1  issue stage reserves a destination register
alloc_addr  in  3  register being reserved
wb_stall  in  1  inhibits FIFO drain this cycle
pending  out  8  bit i = write to register i outstanding
count  out  $clog2(DEPTH)+1  current FIFO occupancy
rf_we  out  1  to register file we
rf_wr_addr  out  3  to register file wr_addr
rf_wr_data  out  WIDTH  to register file wr_data

Behaviour:
Reset:
- While rst is high: count=0, read/write pointers=0, pending=0, last_grant=ALU.
- While rst is high: alu_ready=0, mem_ready=0, rf_we=0, rf_wr_addr=0, rf_wr_data=0.
- Asserting rst mid-operation discards all FIFO contents; those writes are lost.

Acceptance and arbitration:
- At most one producer is accepted per cycle.
- full = (count==DEPTH). Readies are combinational and both are 0 when full.
- A drain in the same cycle does not free a slot for that cycle (no pass-through).
- Only one producer valid and not full: that producer's ready=1.
- Both valid and not full: grant the producer other than last_grant; the other producer's ready=0.
- last_grant updates to the accepted producer on every accepted transfer.
- After reset the first conflict goes to MEM.
- Ready may be high with valid low; a ready without a matching valid does not count as a transfer.
- An accepted {addr,data} is written at the tail on the clock edge; tail pointer wraps mod DEPTH.

Drain:
- rf_we = (count!=0) && !wb_stall.
- rf_wr_addr/rf_wr_data = head entry, combinational from registered storage. Both read 0 when count==0.
- On an edge with rf_we=1, the head pointer advances (wraps mod DEPTH).
- Latency: result accepted at edge N appears on rf_* during cycle N+1 (FIFO otherwise empty, no stall). It is written to the register file at edge N+1.
- Order into the register file equals acceptance order.

Count:
- count' = count + accept - drain.
- Simultaneous accept and drain leaves count unchanged.

Scoreboard:
- alloc_valid at an edge sets pending[alloc_addr].
- A drain at an edge clears pending[rf_wr_addr].
- Same edge, same address for alloc and drain: the bit ends set (alloc wins).
- Alloc of an already-pending address is illegal. The issue stage stalls instead; the bench asserts this never happens.
- A producer writing a non-pending address is also illegal (assertion).
- pending is a registered output.

Test Plan:
- Reset, then alloc r3; alu_valid, alu_addr=3, alu_data=0xDEADBEEF -> alu_ready=1. Next cycle rf_we=1, rf_wr_addr=3, rf_wr_data=0xDEADBEEF. After that edge pending[3]=0 and count=0.
- Alloc r1 and r2; alu(r1,0x11) and mem(r2,0x22) valid together from reset -> MEM accepted first, ALU next cycle. Register writes appear in order r2=0x22 then r1=0x11.
- wb_stall=1, 4 ALU writes to r4..r7 -> count=4 and alu_ready=0 on the 5th attempt. Release stall -> four writes drain in order over 4 cycles, then count=0 and rf_we=0.
- Stall released at full with alu_valid held -> no accept in the drain cycle (count 4->3). Accept happens the following cycle.
- Alloc r5 on the same edge that drains a write to r5 (previous r5 write) -> pending[5] stays 1.
- Assert rst with count=3 -> immediately rf_we=0, readies=0, pending=0. After release count=0 and no stale writes occur.
